// File: rtl/cache_controller.sv
// cache_controller: sequences CPU word requests against a direct-mapped cache and a line-wide memory port.
// Handles lookup, victim write-back, line fetch, refill and a single retry; owns cache initialisation.
module cache_controller #(
   parameter int ADDRESS_SIZE           = 32,
   parameter int BLOCK_SIZE             = 32,
   parameter int NUM_OF_BLOCKS_PER_LINE = 4,
   parameter int CACHE_LATENCY          = 2,
   parameter int INIT_CYCLES            = 3,
   localparam int LINE_W = NUM_OF_BLOCKS_PER_LINE * BLOCK_SIZE,
   localparam int OFS    = $clog2(NUM_OF_BLOCKS_PER_LINE)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_valid_i,
   input  logic                    req_write_i,
   input  logic [ADDRESS_SIZE-1:0] req_addr_i,
   input  logic [BLOCK_SIZE-1:0]   req_wdata_i,
   output logic                    req_ready_o,
   output logic                    resp_valid_o,
   output logic [BLOCK_SIZE-1:0]   resp_rdata_o,
   output logic                    resp_err_o,
   output logic                    cache_rst_n_o,
   output logic                    cache_read_o,
   output logic                    cache_write_o,
   output logic                    cache_read_line_o,
   output logic                    cache_write_line_o,
   output logic [ADDRESS_SIZE-1:0] cache_address_o,
   output logic [BLOCK_SIZE-1:0]   cache_data_o,
   output logic [LINE_W-1:0]       cache_line_o,
   input  logic                    cache_hit_i,
   input  logic                    cache_read_flush_i,
   input  logic                    cache_read_fetch_i,
   input  logic                    cache_write_flush_i,
   input  logic                    cache_write_fetch_i,
   input  logic [BLOCK_SIZE-1:0]   cache_data_i,
   input  logic [LINE_W-1:0]       cache_line_i,
   input  logic [ADDRESS_SIZE-1:0] cache_victim_addr_i,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [ADDRESS_SIZE-1:0] mem_addr_o,
   output logic [LINE_W-1:0]       mem_wline_o,
   input  logic                    mem_ack_i,
   input  logic [LINE_W-1:0]       mem_rline_i
);
   localparam int CW = $clog2(INIT_CYCLES + CACHE_LATENCY + 2);
   typedef enum logic [3:0] {
      S_INIT, S_IDLE, S_LOOKUP, S_WAIT, S_RD_LINE, S_LWAIT, S_WB, S_FETCH, S_WR_LINE, S_RETRY, S_RESP
   } state_t;
   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [ADDRESS_SIZE-1:0] addr_q, addr_d, vaddr_q, vaddr_d;
   logic [BLOCK_SIZE-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
   logic [LINE_W-1:0]       vline_q, vline_d, fline_q, fline_d;
   logic                    wr_q, wr_d, retried_q, retried_d, err, done;
   assign done         = cnt_q == CW'(CACHE_LATENCY);
   assign resp_rdata_o = rdata_q;
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wr_d      = wr_q;
      wdata_d   = wdata_q;
      vaddr_d   = vaddr_q;
      vline_d   = vline_q;
      fline_d   = fline_q;
      retried_d = retried_q;
      rdata_d   = rdata_q;
      err       = 1'b0;
      case (state_q)
         S_INIT:    if (cnt_q == CW'(INIT_CYCLES)) state_d = S_IDLE;
         S_IDLE:    if (req_valid_i) begin
            addr_d    = req_addr_i;
            wr_d      = req_write_i;
            wdata_d   = req_wdata_i;
            retried_d = 1'b0;
            state_d   = S_LOOKUP;
         end
         S_LOOKUP:  state_d = S_WAIT;
         S_WAIT:    if (done) begin
            if (cache_hit_i) begin
               state_d = S_RESP;
               rdata_d = wr_q ? rdata_q : cache_data_i;
            end else if (retried_q) begin
               state_d = S_IDLE;
               err     = 1'b1;
            end else begin
               // Fetch flags and the no-flag case share the plain refill path.
               state_d = (cache_read_flush_i | cache_write_flush_i) ? S_RD_LINE : S_FETCH;
            end
         end
         S_RD_LINE: state_d = S_LWAIT;
         S_LWAIT:   if (done) begin
            vline_d = cache_line_i;
            vaddr_d = cache_victim_addr_i;
            state_d = S_WB;
         end
         S_WB:      if (mem_ack_i) state_d = S_FETCH;
         S_FETCH:   if (mem_ack_i) begin
            fline_d = mem_rline_i;
            state_d = S_WR_LINE;
         end
         S_WR_LINE: state_d = S_RETRY;
         S_RETRY: begin
            retried_d = 1'b1;
            state_d   = S_LOOKUP;
         end
         S_RESP:    state_d = S_IDLE;
         default:   state_d = S_INIT;
      endcase
      cnt_d = (state_d == state_q) ? cnt_q + CW'(1) : '0;
   end
   // Every output is a flop loaded from the next-state decode, so it is glitch-free.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q            <= S_INIT;
         cnt_q              <= '0;
         addr_q             <= '0;
         wr_q               <= 1'b0;
         wdata_q            <= '0;
         vaddr_q            <= '0;
         vline_q            <= '0;
         fline_q            <= '0;
         retried_q          <= 1'b0;
         rdata_q            <= '0;
         req_ready_o        <= 1'b0;
         resp_valid_o       <= 1'b0;
         resp_err_o         <= 1'b0;
         cache_rst_n_o      <= 1'b0;
         cache_read_o       <= 1'b0;
         cache_write_o      <= 1'b0;
         cache_read_line_o  <= 1'b0;
         cache_write_line_o <= 1'b0;
         cache_address_o    <= '0;
         cache_data_o       <= '0;
         cache_line_o       <= '0;
         mem_req_o          <= 1'b0;
         mem_we_o           <= 1'b0;
         mem_addr_o         <= '0;
         mem_wline_o        <= '0;
      end else begin
         state_q            <= state_d;
         cnt_q              <= cnt_d;
         addr_q             <= addr_d;
         wr_q               <= wr_d;
         wdata_q            <= wdata_d;
         vaddr_q            <= vaddr_d;
         vline_q            <= vline_d;
         fline_q            <= fline_d;
         retried_q          <= retried_d;
         rdata_q            <= rdata_d;
         req_ready_o        <= state_d == S_IDLE;
         resp_valid_o       <= state_d == S_RESP;
         resp_err_o         <= err;
         cache_rst_n_o      <= state_d != S_INIT;
         cache_read_o       <= state_d == S_LOOKUP && !wr_d;
         cache_write_o      <= state_d == S_LOOKUP && wr_d;
         cache_read_line_o  <= state_d == S_RD_LINE;
         cache_write_line_o <= state_d == S_WR_LINE;
         cache_address_o    <= (state_d == S_LOOKUP || state_d == S_RD_LINE || state_d == S_WR_LINE) ? addr_d : '0;
         cache_data_o       <= (state_d == S_LOOKUP && wr_d) ? wdata_d : '0;
         cache_line_o       <= state_d == S_WR_LINE ? fline_d : '0;
         mem_req_o          <= state_d == S_WB || state_d == S_FETCH;
         mem_we_o           <= state_d == S_WB;
         mem_addr_o         <= state_d == S_WB ? vaddr_d :
                               state_d == S_FETCH ? {addr_d[ADDRESS_SIZE-1:OFS], {OFS{1'b0}}} : '0;
         mem_wline_o        <= state_d == S_WB ? vline_d : '0;
      end
   end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed scenarios for cache_controller with the bench acting as cache and memory.
module tb_cache_controller;
   localparam int AW = 32, BW = 32, LW = 128;
   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          req_valid_i = 1'b0, req_write_i = 1'b0;
   logic [AW-1:0] req_addr_i = '0;
   logic [BW-1:0] req_wdata_i = '0;
   logic          req_ready_o, resp_valid_o, resp_err_o, cache_rst_n_o;
   logic [BW-1:0] resp_rdata_o;
   logic          cache_read_o, cache_write_o, cache_read_line_o, cache_write_line_o;
   logic [AW-1:0] cache_address_o;
   logic [BW-1:0] cache_data_o;
   logic [LW-1:0] cache_line_o;
   logic          cache_hit_i = 1'b0, cache_read_flush_i = 1'b0, cache_read_fetch_i = 1'b0;
   logic          cache_write_flush_i = 1'b0, cache_write_fetch_i = 1'b0;
   logic [BW-1:0] cache_data_i = '0;
   logic [LW-1:0] cache_line_i = '0;
   logic [AW-1:0] cache_victim_addr_i = '0;
   logic          mem_req_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [LW-1:0] mem_wline_o;
   logic          mem_ack_i = 1'b0;
   logic [LW-1:0] mem_rline_i = '0;
   int            n_chk = 0, n_fail = 0;
   cache_controller dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .req_ready_o(req_ready_o), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
      .cache_rst_n_o(cache_rst_n_o), .cache_read_o(cache_read_o), .cache_write_o(cache_write_o),
      .cache_read_line_o(cache_read_line_o), .cache_write_line_o(cache_write_line_o),
      .cache_address_o(cache_address_o), .cache_data_o(cache_data_o), .cache_line_o(cache_line_o),
      .cache_hit_i(cache_hit_i), .cache_read_flush_i(cache_read_flush_i), .cache_read_fetch_i(cache_read_fetch_i),
      .cache_write_flush_i(cache_write_flush_i), .cache_write_fetch_i(cache_write_fetch_i),
      .cache_data_i(cache_data_i), .cache_line_i(cache_line_i), .cache_victim_addr_i(cache_victim_addr_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wline_o(mem_wline_o),
      .mem_ack_i(mem_ack_i), .mem_rline_i(mem_rline_i)
   );
   always #5 clk_i = ~clk_i;
   initial begin
      #100000;
      $fatal(1, "FAIL watchdog: simulation did not finish");
   end
   task automatic step;
      @(posedge clk_i);
      #1;
   endtask
   task automatic test_reset;
      rst_i = 1'b1;
      step;
      step;
      rst_i = 1'b0;
      n_chk++;
      if ({cache_rst_n_o, req_ready_o, mem_req_o, mem_we_o, cache_read_o, cache_write_o, cache_read_line_o,
           cache_write_line_o, resp_valid_o, resp_err_o} !== 10'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b required 0", {cache_rst_n_o, req_ready_o, mem_req_o, mem_we_o,
                  cache_read_o, cache_write_o, cache_read_line_o, cache_write_line_o, resp_valid_o, resp_err_o});
      end
      n_chk++;
      if ({mem_addr_o, cache_address_o, cache_data_o, resp_rdata_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_buses: mem_addr %h cache_addr %h required 0", mem_addr_o, cache_address_o);
      end
      step;
      step;
      step;
      n_chk++;
      if ({cache_rst_n_o, req_ready_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL init_hold: rst_n/ready %b required 00", {cache_rst_n_o, req_ready_o});
      end
      step;
      n_chk++;
      if ({cache_rst_n_o, req_ready_o} !== 2'b11) begin
         n_fail++;
         $display("FAIL init_release: rst_n/ready %b required 11", {cache_rst_n_o, req_ready_o});
      end
   endtask
   task automatic test_cold_read;
      logic [LW-1:0] line;
      line = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
      cache_read_fetch_i = 1'b1;
      req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h0000_0105;
      step;
      req_valid_i = 1'b0;
      n_chk++;
      if ({cache_read_o, cache_write_o, req_ready_o, cache_address_o} !== {3'b100, 32'h0000_0105}) begin
         n_fail++;
         $display("FAIL cold_lookup: rd/wr/ready %b addr %h required 100 00000105",
                  {cache_read_o, cache_write_o, req_ready_o}, cache_address_o);
      end
      step;
      n_chk++;
      if (cache_read_o !== 1'b0) begin
         n_fail++;
         $display("FAIL cold_pulse_width: cache_read_o %b required 0", cache_read_o);
      end
      step;
      step;
      step;
      n_chk++;
      if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h0000_0104}) begin
         n_fail++;
         $display("FAIL cold_fetch: req/we %b addr %h required 10 00000104", {mem_req_o, mem_we_o}, mem_addr_o);
      end
      mem_ack_i = 1'b1; mem_rline_i = line;
      step;
      mem_ack_i = 1'b0;
      n_chk++;
      if ({cache_write_line_o, mem_req_o, cache_address_o, cache_line_o} !== {2'b10, 32'h0000_0105, line}) begin
         n_fail++;
         $display("FAIL cold_write_line: wl/req %b addr %h line %h", {cache_write_line_o, mem_req_o},
                  cache_address_o, cache_line_o);
      end
      cache_read_fetch_i = 1'b0; cache_hit_i = 1'b1; cache_data_i = 32'hBBBBBBBB;
      step;
      step;
      n_chk++;
      if ({cache_read_o, cache_write_line_o} !== 2'b10) begin
         n_fail++;
         $display("FAIL cold_retry_lookup: rd/wl %b required 10", {cache_read_o, cache_write_line_o});
      end
      step;
      step;
      step;
      step;
      n_chk++;
      if ({resp_valid_o, resp_err_o, resp_rdata_o} !== {2'b10, 32'hBBBBBBBB}) begin
         n_fail++;
         $display("FAIL cold_resp: valid/err %b rdata %h required 10 bbbbbbbb", {resp_valid_o, resp_err_o}, resp_rdata_o);
      end
      step;
      n_chk++;
      if ({resp_valid_o, req_ready_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL cold_idle: valid/ready %b required 01", {resp_valid_o, req_ready_o});
      end
   endtask
   task automatic test_write_hit;
      int  lat;
      logic saw_mem;
      cache_hit_i = 1'b1;
      req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h0000_0104; req_wdata_i = 32'h12345678;
      step;
      req_valid_i = 1'b0;
      n_chk++;
      if ({cache_write_o, cache_read_o, cache_address_o, cache_data_o} !== {2'b10, 32'h0000_0104, 32'h12345678}) begin
         n_fail++;
         $display("FAIL wr_lookup: wr/rd %b addr %h data %h", {cache_write_o, cache_read_o}, cache_address_o, cache_data_o);
      end
      lat = 0;
      saw_mem = 1'b0;
      while (!resp_valid_o && lat < 20) begin
         step;
         lat++;
         saw_mem |= mem_req_o;
      end
      n_chk++;
      if (resp_valid_o !== 1'b1 || lat != 4) begin
         n_fail++;
         $display("FAIL wr_latency: valid %b after %0d cycles required 1 after 4", resp_valid_o, lat);
      end
      n_chk++;
      if (saw_mem !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_no_mem: mem_req seen %b required 0", saw_mem);
      end
      n_chk++;
      if (resp_rdata_o !== 32'hBBBBBBBB) begin
         n_fail++;
         $display("FAIL wr_rdata_hold: rdata %h required bbbbbbbb", resp_rdata_o);
      end
      step;
   endtask
   task automatic test_dirty_conflict;
      logic [LW-1:0] victim;
      victim = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'h12345678};
      cache_hit_i = 1'b0; cache_write_flush_i = 1'b1;
      cache_line_i = victim; cache_victim_addr_i = 32'h0000_0104;
      req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h0000_0114;
      step;
      req_valid_i = 1'b0;
      step;
      step;
      step;
      step;
      n_chk++;
      if ({cache_read_line_o, cache_address_o} !== {1'b1, 32'h0000_0114}) begin
         n_fail++;
         $display("FAIL dirty_read_line: rl %b addr %h required 1 00000114", cache_read_line_o, cache_address_o);
      end
      step;
      step;
      step;
      step;
      cache_line_i = '0; cache_victim_addr_i = '0;
      n_chk++;
      if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b11, 32'h0000_0104}) begin
         n_fail++;
         $display("FAIL dirty_wb: req/we %b addr %h required 11 00000104", {mem_req_o, mem_we_o}, mem_addr_o);
      end
      n_chk++;
      if (mem_wline_o !== victim) begin
         n_fail++;
         $display("FAIL dirty_wline: %h required %h", mem_wline_o, victim);
      end
      mem_ack_i = 1'b1;
      step;
      mem_ack_i = 1'b0;
      n_chk++;
      if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h0000_0114}) begin
         n_fail++;
         $display("FAIL dirty_fetch: req/we %b addr %h required 10 00000114", {mem_req_o, mem_we_o}, mem_addr_o);
      end
   endtask
   task automatic test_mem_stall;
      int lat;
      logic [LW-1:0] line;
      line = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11112222};
      for (int i = 0; i < 10; i++) begin
         step;
         n_chk++;
         if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h0000_0114}) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: req/we %b addr %h required 10 00000114", i, {mem_req_o, mem_we_o}, mem_addr_o);
         end
      end
      cache_write_flush_i = 1'b0; cache_hit_i = 1'b1; cache_data_i = 32'h11112222;
      mem_ack_i = 1'b1; mem_rline_i = line;
      step;
      mem_ack_i = 1'b0;
      n_chk++;
      if ({cache_write_line_o, mem_req_o, cache_line_o} !== {2'b10, line}) begin
         n_fail++;
         $display("FAIL stall_write_line: wl/req %b line %h", {cache_write_line_o, mem_req_o}, cache_line_o);
      end
      lat = 0;
      while (!resp_valid_o && lat < 20) begin
         step;
         lat++;
      end
      n_chk++;
      if (resp_valid_o !== 1'b1 || lat != 6 || resp_rdata_o !== 32'h11112222) begin
         n_fail++;
         $display("FAIL stall_resp: valid %b after %0d rdata %h required 1 after 6 11112222", resp_valid_o, lat, resp_rdata_o);
      end
      step;
   endtask
   task automatic test_retry_err;
      int   lat;
      logic saw_valid;
      cache_hit_i = 1'b0;
      req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h0000_0203;
      step;
      req_valid_i = 1'b0;
      lat = 0;
      while (!mem_req_o && lat < 20) begin
         step;
         lat++;
      end
      n_chk++;
      if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h0000_0200}) begin
         n_fail++;
         $display("FAIL noflag_fetch: req/we %b addr %h required 10 00000200", {mem_req_o, mem_we_o}, mem_addr_o);
      end
      mem_ack_i = 1'b1;
      step;
      mem_ack_i = 1'b0;
      lat = 0;
      saw_valid = 1'b0;
      while (!resp_err_o && lat < 20) begin
         step;
         lat++;
         saw_valid |= resp_valid_o;
      end
      n_chk++;
      if ({resp_err_o, saw_valid, req_ready_o} !== 3'b101 || lat != 6) begin
         n_fail++;
         $display("FAIL retry_err: err/valid/ready %b after %0d required 101 after 6", {resp_err_o, saw_valid, req_ready_o}, lat);
      end
      step;
      n_chk++;
      if (resp_err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL retry_err_pulse: err %b required 0", resp_err_o);
      end
   endtask
   task automatic test_reset_mid_wb;
      int   lat;
      logic saw_valid;
      cache_read_flush_i = 1'b1; cache_victim_addr_i = 32'h0000_0304;
      req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h0000_0300;
      step;
      lat = 0;
      while (!mem_req_o && lat < 20) begin
         step;
         lat++;
      end
      n_chk++;
      if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b11, 32'h0000_0304}) begin
         n_fail++;
         $display("FAIL rstwb_wb: req/we %b addr %h required 11 00000304", {mem_req_o, mem_we_o}, mem_addr_o);
      end
      rst_i = 1'b1;
      step;
      rst_i = 1'b0;
      req_valid_i = 1'b0;
      n_chk++;
      if ({mem_req_o, cache_rst_n_o, req_ready_o, resp_valid_o, resp_err_o} !== 5'b0) begin
         n_fail++;
         $display("FAIL rstwb_drop: req/rst_n/ready/valid/err %b required 00000",
                  {mem_req_o, cache_rst_n_o, req_ready_o, resp_valid_o, resp_err_o});
      end
      lat = 0;
      saw_valid = 1'b0;
      while (!cache_rst_n_o && lat < 20) begin
         step;
         lat++;
         saw_valid |= resp_valid_o | mem_req_o;
      end
      n_chk++;
      if ({cache_rst_n_o, req_ready_o, saw_valid} !== 3'b110 || lat != 4) begin
         n_fail++;
         $display("FAIL rstwb_reinit: rst_n/ready/activity %b after %0d required 110 after 4",
                  {cache_rst_n_o, req_ready_o, saw_valid}, lat);
      end
   endtask
   initial begin
      test_reset;
      test_cold_read;
      test_write_hit;
      test_dirty_conflict;
      test_mem_stall;
      test_retry_err;
      test_reset_mid_wb;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
